// File: rtl/cursor_pkg.sv
// Shared constants for the cursor overlay: arrow sprite, shape codes, default raster size.
// Sprite rows are 2 bits per pixel, LSB pair is column 0.
package cursor_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned V_ACTIVE_DEF = 480;

   localparam logic [1:0] CODE_TRANSP  = 2'b00;
   localparam logic [1:0] CODE_FILL    = 2'b01;
   localparam logic [1:0] CODE_OUTLINE = 2'b10;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
   } pos_t;

   // Left-edge arrow: outlined wedge over rows 0..11, notched tail below.
   localparam logic [31:0] ARROW [16] = '{
      32'h0000_0002, 32'h0000_000A, 32'h0000_0026, 32'h0000_0096,
      32'h0000_0256, 32'h0000_0956, 32'h0000_2556, 32'h0000_9556,
      32'h0002_5556, 32'h0009_5556, 32'h0025_5556, 32'h0095_5556,
      32'h0000_9656, 32'h0000_960A, 32'h0002_5800, 32'h0000_A000
   };

   function automatic logic [1:0] arrow_code(input logic [3:0] row, input logic [3:0] col);
      logic [31:0] bits;
      bits = ARROW[row];
      return bits[{col, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/cursor_overlay_if.sv
// VGA pixel stream into and out of the cursor overlay.
// The source drives the raster inputs; the overlay drives the delayed, composited outputs.
interface cursor_overlay_if;

   logic        pix_en;
   logic [9:0]  vga_x;
   logic [9:0]  vga_y;
   logic        vga_hs_in;
   logic        vga_vs_in;
   logic        vga_blank_n_in;
   logic [23:0] rgb_in;
   logic [23:0] rgb_out;
   logic        vga_hs_out;
   logic        vga_vs_out;
   logic        vga_blank_n_out;

   modport master (
      output pix_en, vga_x, vga_y, vga_hs_in, vga_vs_in, vga_blank_n_in, rgb_in,
      input  rgb_out, vga_hs_out, vga_vs_out, vga_blank_n_out
   );

   modport slave (
      input  pix_en, vga_x, vga_y, vga_hs_in, vga_vs_in, vga_blank_n_in, rgb_in,
      output rgb_out, vga_hs_out, vga_vs_out, vga_blank_n_out
   );

endinterface

// File: rtl/cursor_pos_sync.sv
// Brings the asynchronous mouse position into clk_50 and only accepts a value once two
// consecutive synchronized samples agree, so a torn multi-bit update never gets through.
module cursor_pos_sync
   import cursor_pkg::*;
(
   input  logic       clk_50,
   input  logic       reset_n,
   input  logic [9:0] mouse_x,
   input  logic [9:0] mouse_y,
   output pos_t       pos_stable
);

   pos_t meta_q;
   pos_t sync_q;
   pos_t prev_q;

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         meta_q     <= '0;
         sync_q     <= '0;
         prev_q     <= '0;
         pos_stable <= '0;
      end else begin
         meta_q <= '{x: mouse_x, y: mouse_y};
         sync_q <= meta_q;
         prev_q <= sync_q;
         if (sync_q == prev_q) begin
            pos_stable <= sync_q;
         end
      end
   end

endmodule

// File: rtl/cursor_overlay.sv
// Latches a frame-coherent cursor position at each vsync fall and composites a 16x16
// arrow sprite onto the pixel stream through a two-strobe pipeline; hides it when idle.
module cursor_overlay
   import cursor_pkg::*;
#(
   parameter int unsigned H_ACTIVE      = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE      = V_ACTIVE_DEF,
   parameter int unsigned HIDE_FRAMES   = 180,
   parameter logic [23:0] FILL_COLOR    = 24'hFFFFFF,
   parameter logic [23:0] OUTLINE_COLOR = 24'h000000
) (
   input  logic             clk_50,
   input  logic             reset_n,
   input  logic [9:0]       mouse_x,
   input  logic [9:0]       mouse_y,
   cursor_overlay_if.slave  vid,
   output logic             cursor_visible,
   output logic             frame_tick
);

   localparam logic [9:0] X_MAX = 10'(H_ACTIVE - 1);
   localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - 1);
   localparam int unsigned IDLE_W = (HIDE_FRAMES > 0) ? $clog2(HIDE_FRAMES + 1) : 1;
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(HIDE_FRAMES);

   pos_t              pos_stable;
   logic [9:0]        cx;
   logic [9:0]        cy;
   logic [9:0]        nx;
   logic [9:0]        ny;
   logic              vs_prev;
   logic              latch;
   logic [IDLE_W-1:0] idle_cnt;

   cursor_pos_sync u_sync (
      .clk_50     (clk_50),
      .reset_n    (reset_n),
      .mouse_x    (mouse_x),
      .mouse_y    (mouse_y),
      .pos_stable (pos_stable)
   );

   always_comb begin
      nx    = (pos_stable.x > X_MAX) ? X_MAX : pos_stable.x;
      ny    = (pos_stable.y > Y_MAX) ? Y_MAX : pos_stable.y;
      latch = vid.pix_en & ~vid.vga_vs_in & vs_prev;
   end

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         cx             <= '0;
         cy             <= '0;
         vs_prev        <= 1'b1;
         idle_cnt       <= '0;
         cursor_visible <= 1'b1;
         frame_tick     <= 1'b0;
      end else begin
         frame_tick <= latch;
         if (vid.pix_en) begin
            vs_prev <= vid.vga_vs_in;
         end
         if (latch) begin
            cx <= nx;
            cy <= ny;
            if (nx != cx || ny != cy || HIDE_FRAMES == 0) begin
               idle_cnt       <= '0;
               cursor_visible <= 1'b1;
            end else if (idle_cnt != IDLE_MAX) begin
               idle_cnt <= idle_cnt + 1'b1;
               if (idle_cnt == IDLE_MAX - 1'b1) begin
                  cursor_visible <= 1'b0;
               end
            end
         end
      end
   end

   // Stage 1: sprite-relative offsets; a negative or >=16 offset shows up in bits [10:4].
   logic [10:0] dx;
   logic [10:0] dy;
   logic        hit;

   always_comb begin
      dx  = {1'b0, vid.vga_x} - {1'b0, cx};
      dy  = {1'b0, vid.vga_y} - {1'b0, cy};
      hit = cursor_visible & vid.vga_blank_n_in & (dx[10:4] == '0) & (dy[10:4] == '0);
   end

   logic [3:0]  s1_dx;
   logic [3:0]  s1_dy;
   logic        s1_hit;
   logic [23:0] s1_rgb;
   logic        s1_hs;
   logic        s1_vs;
   logic        s1_blank_n;

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         s1_dx      <= '0;
         s1_dy      <= '0;
         s1_hit     <= 1'b0;
         s1_rgb     <= '0;
         s1_hs      <= 1'b1;
         s1_vs      <= 1'b1;
         s1_blank_n <= 1'b0;
      end else if (vid.pix_en) begin
         s1_dx      <= dx[3:0];
         s1_dy      <= dy[3:0];
         s1_hit     <= hit;
         s1_rgb     <= vid.rgb_in;
         s1_hs      <= vid.vga_hs_in;
         s1_vs      <= vid.vga_vs_in;
         s1_blank_n <= vid.vga_blank_n_in;
      end
   end

   // Stage 2: sprite lookup and composite.
   logic [1:0]  code;
   logic [23:0] rgb_mix;

   always_comb begin
      code    = arrow_code(s1_dy, s1_dx);
      rgb_mix = s1_rgb;
      if (s1_hit) begin
         case (code)
            CODE_FILL:    rgb_mix = FILL_COLOR;
            CODE_OUTLINE: rgb_mix = OUTLINE_COLOR;
            default:      rgb_mix = s1_rgb;
         endcase
      end
      if (!s1_blank_n) begin
         rgb_mix = '0;
      end
   end

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         vid.rgb_out         <= '0;
         vid.vga_hs_out      <= 1'b1;
         vid.vga_vs_out      <= 1'b1;
         vid.vga_blank_n_out <= 1'b0;
      end else if (vid.pix_en) begin
         vid.rgb_out         <= rgb_mix;
         vid.vga_hs_out      <= s1_hs;
         vid.vga_vs_out      <= s1_vs;
         vid.vga_blank_n_out <= s1_blank_n;
      end
   end

endmodule
